// File: rtl/uart_rx_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
//
// Shared constants and types for the UART receive controller:
//   DATA_WIDTH     - default number of data bits per frame
//   PRESCALE_WIDTH - default width of the prescale value and edge counter
//   BIT_CNT_W      - width of the data bit index
//   rx_state_e     - receive FSM states (fixed 3-bit encoding)
//   frame_bits()   - number of bit periods in one frame
// ----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int PRESCALE_WIDTH = 6;
    localparam int BIT_CNT_W      = 4;

    // The encoding is shared with other blocks, so the values are pinned.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Start bit + data bits + optional parity bit + stop bit.
    function automatic int frame_bits(input int width, input logic par_en);
        return 2 + width + (par_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_cnt.sv
// ----------------------------------------------------------------------------
// rx_edge_bit_cnt
//
// Oversampling edge counter and data bit counter for the UART receiver.
// The prescale ratio is captured when a frame starts so that a change on
// the prescale input mid-frame cannot disturb bit timing.
//
// Ports:
//   i_clk, i_rst    clock, asynchronous active-low reset
//   i_cnt_en        count edges (FSM is outside IDLE); edge counter held at 0
//                   otherwise
//   i_prescale_ld   capture i_prescale as the ratio for the coming frame
//   i_prescale      oversampling ratio (8, 16 or 32)
//   i_bit_clr       clear the bit counter
//   i_bit_inc       advance the bit counter
//   o_edge_cnt      edge position within the current bit
//   o_bit_cnt       data bit index
//   o_tick          last edge of the current bit period
// ----------------------------------------------------------------------------
module rx_edge_bit_cnt
    import uart_rx_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cnt_en,
    input  logic                  i_prescale_ld,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_bit_clr,
    input  logic                  i_bit_inc,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_tick
);

    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);

    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic                  tick;

    // The ratio is always at least 4, so subtracting one never wraps.
    assign tick = i_cnt_en && (edge_cnt_q == (prescale_q - EDGE_ONE));

    always_comb begin
        prescale_d = prescale_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        if (i_prescale_ld) begin
            prescale_d = i_prescale;
        end

        if (!i_cnt_en || tick) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + EDGE_ONE;
        end

        if (i_bit_clr) begin
            bit_cnt_d = '0;
        end else if (i_bit_inc) begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            prescale_q <= '0;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            prescale_q <= prescale_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign o_edge_cnt = edge_cnt_q;
    assign o_bit_cnt  = bit_cnt_q;
    assign o_tick     = tick;

endmodule

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
//
// UART receive controller. Detects the start edge, walks the frame one bit
// period at a time, deserializes the data bits LSB first, sequences the
// external parity checker and the stop-bit check, and publishes each frame
// result as a one-cycle strobe.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-low reset
//   i_rx_in          synchronized serial line, idle high
//   i_prescale       oversampling ratio (8, 16, 32), captured at frame start
//   i_par_en         frame carries a parity bit
//   i_sampled_bit    majority-voted bit from the sampler
//   i_par_err        registered result from the parity checker
//   o_sample_en      sampler enable, high outside IDLE
//   o_edge_cnt       edge position within the current bit
//   o_bit_cnt        data bit index
//   o_par_chk_en     parity checker enable, one cycle on the parity bit tick
//   o_shift_data     deserializer contents, fed to the parity checker
//   o_data           last correctly received word
//   o_data_valid     strobe: good frame
//   o_par_err        strobe: parity failure
//   o_stop_err       strobe: framing (stop bit) failure
// ----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int WIDTH      = DATA_WIDTH,
    parameter int PRESCALE_W = PRESCALE_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_in,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_par_en,
    input  logic                  i_sampled_bit,
    input  logic                  i_par_err,
    output logic                  o_sample_en,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [3:0]            o_bit_cnt,
    output logic                  o_par_chk_en,
    output logic [WIDTH-1:0]      o_shift_data,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stop_err
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  par_frame_q, par_frame_d;
    logic                  par_fail_q, par_fail_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;

    logic                  cnt_en;
    logic                  prescale_ld;
    logic                  bit_clr;
    logic                  bit_inc;
    logic                  tick;
    logic                  par_chk_en;
    logic                  stop_fail;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign cnt_en = (state_q != ST_IDLE);

    rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W)
    ) u_edge_bit_cnt (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cnt_en      (cnt_en),
        .i_prescale_ld (prescale_ld),
        .i_prescale    (i_prescale),
        .i_bit_clr     (bit_clr),
        .i_bit_inc     (bit_inc),
        .o_edge_cnt    (edge_cnt),
        .o_bit_cnt     (bit_cnt),
        .o_tick        (tick)
    );

    // Next-state, deserializer and result logic. Strobes default low so
    // each one lives for exactly the cycle after the stop tick.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        data_d      = data_q;
        par_frame_d = par_frame_q;
        par_fail_d  = par_fail_q;
        valid_d     = 1'b0;
        par_err_d   = 1'b0;
        stop_err_d  = 1'b0;
        prescale_ld = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        par_chk_en  = 1'b0;
        stop_fail   = ~i_sampled_bit;

        case (state_q)
            ST_IDLE: begin
                bit_clr = 1'b1;
                if (!i_rx_in) begin
                    state_d     = ST_START;
                    prescale_ld = 1'b1;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (!i_sampled_bit) begin
                        state_d = ST_DATA;
                        bit_clr = 1'b1;
                    end else begin
                        // Line went high again before mid-start: a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    shift_d = {i_sampled_bit, shift_q[WIDTH-1:1]};
                    bit_inc = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        par_frame_d = i_par_en;
                        state_d     = i_par_en ? ST_PARITY : ST_STOP;
                    end
                end
            end

            ST_PARITY: begin
                par_chk_en = tick;
                if (tick) begin
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                // The checker answers one cycle after its enable, which is
                // the first STOP cycle (edge count 0).
                if (edge_cnt == '0) begin
                    par_fail_d = par_frame_q & i_par_err;
                end
                if (tick) begin
                    stop_err_d = stop_fail;
                    par_err_d  = par_fail_q & ~stop_fail;
                    valid_d    = ~par_fail_q & ~stop_fail;
                    if (~par_fail_q & ~stop_fail) begin
                        data_d = shift_q;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            data_q      <= '0;
            par_frame_q <= 1'b0;
            par_fail_q  <= 1'b0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            stop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            par_frame_q <= par_frame_d;
            par_fail_q  <= par_fail_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            stop_err_q  <= stop_err_d;
        end
    end

    assign o_sample_en  = cnt_en;
    assign o_edge_cnt   = edge_cnt;
    assign o_bit_cnt    = bit_cnt;
    assign o_par_chk_en = par_chk_en;
    assign o_shift_data = shift_q;
    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_par_err    = par_err_q;
    assign o_stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Self-checking bench for uart_rx_ctrl. Frames are described as a list of
// bit periods; expected outputs for every cycle follow from frame arithmetic
// (bit period P, frame length N) rather than from the controller's states.
// A small registered parity checker stands in for the neighbouring block.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int W  = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          sampled_bit;
    logic          par_err_in;

    logic          sample_en;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          par_chk_en;
    logic [W-1:0]  shift_data;
    logic [W-1:0]  data;
    logic          data_valid;
    logic          par_err;
    logic          stop_err;

    int            n_compared   = 0;
    int            n_mismatched = 0;
    int            cur_c        = 0;
    logic [W-1:0]  last_good    = '0;

    typedef struct {
        int         p;
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        logic       stop_bit;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_in       (rx_in),
        .i_prescale    (prescale),
        .i_par_en      (par_en),
        .i_sampled_bit (sampled_bit),
        .i_par_err     (par_err_in),
        .o_sample_en   (sample_en),
        .o_edge_cnt    (edge_cnt),
        .o_bit_cnt     (bit_cnt),
        .o_par_chk_en  (par_chk_en),
        .o_shift_data  (shift_data),
        .o_data        (data),
        .o_data_valid  (data_valid),
        .o_par_err     (par_err),
        .o_stop_err    (stop_err)
    );

    // Even-parity checker with one register of latency; its result is only
    // high in the cycle right after its enable.
    always @(posedge clk or negedge rst) begin
        if (!rst) par_err_in <= 1'b0;
        else      par_err_in <= par_chk_en & (^{shift_data, sampled_bit});
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s (cycle t0+%0d): got %0h, expected %0h",
                     name, cur_c, actual, expected);
        end
    endtask

    // Inputs are set just after an edge and sampled by the next one.
    task automatic applyStimulus(input logic rx, input logic smp,
                                 input logic [PW-1:0] pres, input logic pen);
        rx_in       = rx;
        sampled_bit = smp;
        prescale    = pres;
        par_en      = pen;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_result(input logic [7:0] d, input logic pen,
                                              input logic pb, input logic stop);
        logic sf, pf;
        sf = ~stop;
        pf = pen & (^d ^ pb);
        return {~pf & ~sf, pf & ~sf, sf};
    endfunction

    function automatic logic [PW-1:0] pick_p();
        case ($urandom_range(0, 2))
            0:       return PW'(8);
            1:       return PW'(16);
            default: return PW'(32);
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " sample_en"}, 32'(sample_en), 0);
        checkOutput({tag, " edge_cnt"}, 32'(edge_cnt), 0);
        checkOutput({tag, " bit_cnt"}, 32'(bit_cnt), 0);
        checkOutput({tag, " par_chk_en"}, 32'(par_chk_en), 0);
        checkOutput({tag, " shift_data"}, 32'(shift_data), 0);
        checkOutput({tag, " data"}, 32'(data), 0);
        checkOutput({tag, " valid"}, 32'(data_valid), 0);
        checkOutput({tag, " par_err"}, 32'(par_err), 0);
        checkOutput({tag, " stop_err"}, 32'(stop_err), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, PW'(8), 1'b0);
            cur_c = -1;
            checkOutput("idle sample_en", 32'(sample_en), 0);
            checkOutput("idle strobes", {29'd0, data_valid, par_err, stop_err}, 0);
            checkOutput("idle data", 32'(data), 32'(last_good));
        end
    endtask

    // Drives one complete frame; t0 is the edge that samples the start bit.
    // Expected per-cycle values come from bit-period arithmetic only.
    task automatic run_frame(input int p, input logic [7:0] d, input logic pen,
                             input logic pb, input logic stop, input logic ev,
                             input logic epe, input logic ese, input logic scramble);
        logic bits[12];
        int   nb;
        logic rx, smp, pen_drv;
        logic [PW-1:0] pres;
        int   c;

        nb      = 2 + W + (pen ? 1 : 0);
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[1 + i] = d[i];
        if (pen) bits[1 + W] = pb;
        bits[nb - 1] = stop;

        for (int cyc = 0; cyc <= nb * p; cyc++) begin
            rx      = (cyc / p < nb) ? bits[cyc / p] : 1'b1;
            smp     = (cyc == 0) ? 1'b1 : bits[(cyc - 1) / p];
            pres    = (cyc == 0 || !scramble) ? PW'(p) : pick_p();
            pen_drv = (scramble && cyc > (W + 1) * p) ? 1'($urandom_range(0, 1)) : pen;
            applyStimulus(rx, smp, pres, pen_drv);
            c     = cyc + 1;
            cur_c = c;
            if (c == nb * p + 1 && ev) last_good = d;

            checkOutput("sample_en", 32'(sample_en), 32'(c <= nb * p));
            checkOutput("edge_cnt", 32'(edge_cnt), (c <= nb * p) ? 32'((c - 1) % p) : 0);
            checkOutput("par_chk_en", 32'(par_chk_en), 32'(pen && c == (W + 2) * p));
            checkOutput("valid", 32'(data_valid), (c == nb * p + 1) ? 32'(ev) : 0);
            checkOutput("par_err", 32'(par_err), (c == nb * p + 1) ? 32'(epe) : 0);
            checkOutput("stop_err", 32'(stop_err), (c == nb * p + 1) ? 32'(ese) : 0);
            checkOutput("data", 32'(data), 32'(last_good));
        end
    endtask

    initial begin
        logic [2:0] r;
        logic [7:0] rd;
        logic       rpen, rpb, rstop;
        int         rp;

        vecs[0] = '{8,  8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8,  8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8,  8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst         = 1'b0;
        rx_in       = 1'b1;
        sampled_bit = 1'b1;
        prescale    = PW'(8);
        par_en      = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(3);

        // Directed frames from the table.
        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d: P=%0d data=%02h", i, vecs[i].p, vecs[i].data);
            run_frame(vecs[i].p, vecs[i].data, vecs[i].par_en, vecs[i].par_bit,
                      vecs[i].stop_bit, vecs[i].exp_valid, vecs[i].exp_perr,
                      vecs[i].exp_serr, 1'b0);
            idle_cycles(2);
        end

        // Short low glitch on an idle line: abandoned at the START tick.
        $display("[TB] glitch sequence");
        for (int cyc = 0; cyc < 24; cyc++) begin
            applyStimulus((cyc < 3) ? 1'b0 : 1'b1, 1'b1, PW'(16), 1'b0);
            cur_c = cyc + 1;
            checkOutput("glitch sample_en", 32'(sample_en), 32'(cur_c <= 16));
            checkOutput("glitch strobes", {29'd0, data_valid, par_err, stop_err}, 0);
        end

        // Reset in the middle of the data bits of a frame.
        $display("[TB] reset mid-frame sequence");
        for (int cyc = 0; cyc < 100; cyc++) begin
            applyStimulus((cyc < 32) ? 1'b0 : 1'b1,
                          (cyc == 0 || (cyc - 1) / 32 != 0), PW'(32), 1'b0);
        end
        cur_c = 100;
        checkOutput("pre-reset sample_en", 32'(sample_en), 1);
        rst = 1'b0;
        #1;
        check_all_zero("mid reset");
        @(posedge clk); #1;
        check_all_zero("held reset");
        rst       = 1'b1;
        last_good = '0;
        idle_cycles(2);
        run_frame(32, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(32, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);

        // Random frames checked against the frame-level reference model,
        // with prescale and parity-enable disturbed after they are captured.
        for (int n = 0; n < 25; n++) begin
            rd    = 8'($urandom);
            rpen  = 1'($urandom_range(0, 1));
            rpb   = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 4) != 0);
            rp    = int'(pick_p());
            r     = ref_result(rd, rpen, rpb, rstop);
            run_frame(rp, rd, rpen, rpb, rstop, r[2], r[1], r[0], 1'b1);
            idle_cycles($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller: detects the start edge, runs the per-bit oversampling edge counter and bit counter, and deserializes the data bits. It also sequences the parity and stop checks and publishes a received word with a one-cycle valid strobe. It sits between the RX line/data sampler and the parity checker, drives the checker's enable and data, and consumes its registered error result.

## Interface
- `WIDTH` (from `parameters.v`), default 8: data bits per frame.
- `PRESCALE_W`, default 6: width of prescale and edge counter.

- `i_clk`  in  1: clock.
- `i_rst`  in  1: reset, asynchronous, active-low.
- `i_rx_in`  in  1: serial line, already synchronized; idle high.
- `i_prescale`  in  PRESCALE_W: oversampling ratio; legal values 8, 16, 32.
- `i_par_en`  in  1: frame contains a parity bit.
- `i_sampled_bit`  in  1: majority-voted bit from the sampler; stable by edge count `prescale-1`.
- `i_par_err`  in  1: registered parity-checker result.
- `o_sample_en`  out  1: sampler enable; high in every non-IDLE state.
- `o_edge_cnt`  out  PRESCALE_W: edge count within the current bit.
- `o_bit_cnt`  out  4: data bit index.
- `o_par_chk_en`  out  1: parity-check enable pulse.
- `o_shift_data`  out  WIDTH: deserializer contents, fed to the parity checker.
- `o_data`  out  WIDTH: last good word.
- `o_data_valid`  out  1: one-cycle strobe for a good frame.
- `o_par_err`  out  1: one-cycle strobe for a parity failure.
- `o_stop_err`  out  1: one-cycle strobe for a framing failure.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset: the state is IDLE and every counter, register and output is 0.
- Bit tick: occurs when `edge_cnt == P-1`. The edge counter then wraps to 0; otherwise it increments. The edge counter is held at 0 in IDLE.
- `P` is latched from `i_prescale` on the IDLE->START transition. Changing `i_prescale` mid-frame has no effect.
- IDLE: when `i_rx_in == 0`, go to START. The first START cycle has `edge_cnt = 0`.
- START, on tick:
  - `i_sampled_bit == 0`: go to DATA with `bit_cnt = 0`.
  - Otherwise it is a glitch: go to IDLE with no strobes.
- DATA, on tick:
  - Shift right, inserting `i_sampled_bit` at the MSB (LSB-first reception). `bit_cnt` increments.
  - At `bit_cnt == WIDTH-1`, go to PARITY if `i_par_en`, else to STOP.
  - `i_par_en` is sampled at this transition.
- PARITY: `o_par_chk_en` is high combinationally for exactly the tick cycle. Then go to STOP.
- STOP:
  - In the first STOP cycle, latch `i_par_err` into the internal `par_fail` flag. Outside a parity frame, `par_fail` is cleared.
  - On tick: `stop_fail = ~i_sampled_bit`, then go to IDLE.
- Result strobes are registered and asserted in the cycle after the STOP tick:
  - `o_stop_err = stop_fail`.
  - `o_par_err = par_fail & ~stop_fail`. A framing error takes precedence.
  - `o_data_valid = ~par_fail & ~stop_fail`.
  - `o_data` is loaded from the shift register only when `o_data_valid` is asserted; otherwise it holds.
- Back-to-back frames: IDLE is re-entered after the STOP tick. A low `i_rx_in` in that IDLE cycle starts the next frame.
- Reset mid-frame: abort immediately, go to IDLE, no strobes. `o_data` returns to 0.

## Timing
- Frame length: `N = 1 + WIDTH + i_par_en + 1` bits.
- Cycles are counted from t0, the edge where IDLE samples `i_rx_in` low:
  - START occupies cycles t0+1 .. t0+P.
  - The STOP tick is at t0+N·P.
  - Strobes are high in cycle t0+N·P+1.
- `o_par_chk_en` occurs at t0+(WIDTH+2)·P.
- `i_par_err` is captured in the following cycle. This relies on the checker's one-register latency.
- Exactly one of the three strobes fires per completed frame; none fires for a glitch or reset abort.
- Edge counter: `PRESCALE_W` bits, unsigned. `P ≥ 4` is required.

## Structure
- `parameters.v` holds `WIDTH` and the state encodings (3-bit localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
- Sub-module `rx_edge_bit_cnt`: edge counter, bit counter, tick generation, enable/clear from the FSM.
- FSM, deserializer and result registers stay in `uart_rx_ctrl`.

## Test plan
- P=8, parity off, frame 0xA5 with stop=1:
  - `o_data_valid` high only at t0+81.
  - `o_data = 0xA5`; no error strobes.
- P=16, parity even, 0x3C with parity bit 0:
  - One `o_par_chk_en` pulse at t0+160.
  - Valid at t0+177; `o_data = 0x3C`.
- Same frame with parity bit 1:
  - `o_par_err` pulse at t0+177; `o_data_valid` stays 0.
  - `o_data` keeps its previous value.
- P=8, 0x55 with stop=0 and parity fault also injected:
  - `o_stop_err` only; `o_par_err = 0`.
- P=16, 3-cycle low glitch on idle line:
  - Back in IDLE at t0+17; no strobes; `o_sample_en` drops.
- Reset asserted mid-DATA, then released, then back-to-back frames 0x12 and 0x34 at P=32:
  - All outputs 0 during reset.
  - Both words are received with two valid strobes.
